// File: rtl/hextext_pkg.sv
// Shared types and tables for the hex-display message engine: glyphs, char codes,
// message ids, message text lookup and message lengths.
package hextext_pkg;

  localparam int BCD_W = 12;

  // Segment patterns are active-low, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_G     = 7'h42;
  localparam logic [6:0] SEG_H     = 7'h09;
  localparam logic [6:0] SEG_I     = 7'h4F;
  localparam logic [6:0] SEG_M     = 7'h2A;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_Q     = 7'h18;
  localparam logic [6:0] SEG_T     = 7'h07;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_SPACE = 7'h7F;

  // Decimal digits occupy codes 0..9 so a BCD nibble maps straight onto a char.
  typedef enum logic [4:0] {
    CH_0 = 5'd0, CH_1, CH_2, CH_3, CH_4, CH_5, CH_6, CH_7, CH_8, CH_9,
    CH_A, CH_D, CH_E, CH_F, CH_G, CH_H, CH_I, CH_M, CH_N, CH_P, CH_Q, CH_T,
    CH_DASH, CH_BLANK
  } char_t;

  typedef enum logic [2:0] {
    MSG_1P, MSG_2P, MSG_FIGHT, MSG_P1, MSG_P2, MSG_EQ, MSG_NUM, MSG_DEMO
  } msg_id_t;

  function automatic char_t digit_char(input logic [3:0] d);
    return (d > 4'd9) ? CH_BLANK : char_t'({1'b0, d});
  endfunction

  // pos 0 = hundreds, 1 = tens, 2 = ones; leading zeros blank, ones always shown.
  function automatic char_t num_char(input logic [1:0] pos, input logic [BCD_W-1:0] bcd);
    char_t c;
    c = CH_BLANK;
    case (pos)
      2'd0:    if (bcd[11:8] != 4'd0) c = digit_char(bcd[11:8]);
      2'd1:    if (bcd[11:4] != 8'd0) c = digit_char(bcd[7:4]);
      default: c = digit_char(bcd[3:0]);
    endcase
    return c;
  endfunction

  function automatic logic [3:0] msg_len(input msg_id_t id);
    logic [3:0] len;
    case (id)
      MSG_1P, MSG_2P:        len = 4'd2;
      MSG_FIGHT:             len = 4'd5;
      MSG_NUM:               len = 4'd3;
      default:               len = 4'd7;
    endcase
    return len;
  endfunction

  function automatic char_t msg_char(input msg_id_t id, input logic [3:0] idx,
                                     input logic [BCD_W-1:0] bcd);
    char_t c;
    c = CH_BLANK;
    case (id)
      MSG_1P, MSG_2P: begin
        if (idx == 4'd0) c = (id == MSG_1P) ? CH_1 : CH_2;
        else if (idx == 4'd1) c = CH_P;
      end
      MSG_FIGHT: begin
        case (idx)
          4'd0: c = CH_F;
          4'd1: c = CH_I;
          4'd2: c = CH_G;
          4'd3: c = CH_H;
          4'd4: c = CH_T;
          default: c = CH_BLANK;
        endcase
      end
      MSG_P1, MSG_P2, MSG_EQ: begin
        case (idx)
          4'd0:             c = (id == MSG_EQ) ? CH_E : CH_P;
          4'd1:             c = (id == MSG_P1) ? CH_1 : ((id == MSG_P2) ? CH_2 : CH_Q);
          4'd2, 4'd6:       c = CH_DASH;
          4'd3, 4'd4, 4'd5: c = num_char(2'(idx - 4'd3), bcd);
          default:          c = CH_BLANK;
        endcase
      end
      MSG_NUM: begin
        if (idx < 4'd3) c = num_char(idx[1:0], bcd);
      end
      default: begin
        case (idx)
          4'd0:       c = CH_D;
          4'd1:       c = CH_E;
          4'd2, 4'd4: c = CH_M;
          4'd3:       c = CH_0;
          4'd5:       c = CH_A;
          4'd6:       c = CH_N;
          default:    c = CH_BLANK;
        endcase
      end
    endcase
    return c;
  endfunction

  function automatic logic [6:0] glyph(input char_t c);
    logic [6:0] s;
    case (c)
      CH_0: s = SEG_0;   CH_1: s = SEG_1;   CH_2: s = SEG_2;   CH_3: s = SEG_3;
      CH_4: s = SEG_4;   CH_5: s = SEG_5;   CH_6: s = SEG_6;   CH_7: s = SEG_7;
      CH_8: s = SEG_8;   CH_9: s = SEG_9;   CH_A: s = SEG_A;   CH_D: s = SEG_D;
      CH_E: s = SEG_E;   CH_F: s = SEG_F;   CH_G: s = SEG_G;   CH_H: s = SEG_H;
      CH_I: s = SEG_I;   CH_M: s = SEG_M;   CH_N: s = SEG_N;   CH_P: s = SEG_P;
      CH_Q: s = SEG_Q;   CH_T: s = SEG_T;   CH_DASH: s = SEG_DASH;
      default: s = SEG_SPACE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hextext_scroller_if.sv
// Game-FSM <-> hex message engine connection: message request in, segments and status out.
interface hextext_scroller_if #(
  parameter int N_DIGITS = 6,
  parameter int NUM_W    = 7
);
  logic [2:0]            msg_sel;
  logic [NUM_W-1:0]      number;
  logic                  msg_load;
  logic [7*N_DIGITS-1:0] hex_out;
  logic                  busy;
  logic                  scrolling;

  modport master (output msg_sel, number, msg_load, input hex_out, busy, scrolling);
  modport slave  (input msg_sel, number, msg_load, output hex_out, busy, scrolling);
endinterface

// File: rtl/hextext_scroller_bin2bcd_seq.sv
// Serial double-dabble: one bit per cycle, NUM_W cycles from start to a one-cycle done pulse.
module bin2bcd_seq
  import hextext_pkg::*;
#(
  parameter int NUM_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NUM_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);
  localparam int CNT_W = $clog2(NUM_W + 1);

  logic [NUM_W-1:0] bin_reg;
  logic [BCD_W-1:0] bcd_reg;
  logic [BCD_W-1:0] adj_w;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             done_reg;

  for (genvar gi = 0; gi < BCD_W / 4; gi++) begin : g_adj
    assign adj_w[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ? bcd_reg[gi*4 +: 4] + 4'd3
                                                         : bcd_reg[gi*4 +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_reg  <= '0;
      bcd_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else if (start) begin
      bin_reg  <= bin;
      bcd_reg  <= '0;
      cnt_reg  <= CNT_W'(NUM_W);
      busy_reg <= 1'b1;
      done_reg <= 1'b0;
    end else if (busy_reg) begin
      bcd_reg <= {adj_w[BCD_W-2:0], bin_reg[NUM_W-1]};
      bin_reg <= bin_reg << 1;
      cnt_reg <= cnt_reg - CNT_W'(1);
      if (cnt_reg == CNT_W'(1)) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
      end
    end else begin
      done_reg <= 1'b0;
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign bcd  = bcd_reg;

endmodule

// File: rtl/hextext_scroller.sv
// Message engine top: load/convert/show-or-scroll FSM, prescalers and per-digit render.
// Optional HEX_BLINK_EN adds whole-display blinking for the result messages (ids 3-5).
module hextext_scroller
  import hextext_pkg::*;
#(
  parameter int N_DIGITS  = 6,
  parameter int CLK_HZ    = 50_000_000,
  parameter int SCROLL_HZ = 4,
  parameter int BLINK_HZ  = 2,
  parameter int NUM_W     = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  hextext_scroller_if.slave  bus
);
  localparam int SCROLL_DIV = CLK_HZ / SCROLL_HZ;
  localparam int SCROLL_CW  = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [SCROLL_CW-1:0] SCROLL_LAST = SCROLL_CW'(SCROLL_DIV - 1);
  localparam logic [3:0] N_DIG4 = 4'(N_DIGITS);

  typedef enum logic [1:0] {ST_IDLE, ST_CONV, ST_SHOW, ST_SCROLL} state_t;

  state_t                 state_reg, state_next;
  msg_id_t                id_reg;
  msg_id_t                disp_id_reg;
  logic [BCD_W-1:0]       disp_bcd_reg;
  logic                   disp_valid_reg;
  logic [3:0]             off_reg;
  logic [SCROLL_CW-1:0]   scroll_cnt_reg;

  logic                   conv_busy;
  logic                   conv_done;
  logic [BCD_W-1:0]       conv_bcd;
  logic                   update;
  logic                   blank_w;
  logic [3:0]             disp_len;
  logic                   disp_wrap;
  logic [7*N_DIGITS-1:0]  hex_w;

  bin2bcd_seq #(.NUM_W(NUM_W)) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (bus.msg_load),
    .bin   (bus.number),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // A new load in the same cycle as done wins; the stale result is dropped.
  assign update    = (state_reg == ST_CONV) && conv_done && !bus.msg_load;
  assign disp_len  = msg_len(disp_id_reg);
  assign disp_wrap = disp_len > N_DIG4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (bus.msg_load)
      state_next = ST_CONV;
    else if (update)
      state_next = (msg_len(id_reg) > N_DIG4) ? ST_SCROLL : ST_SHOW;
  end

  // Display registers stay frozen during CONV so the old text remains visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_reg         <= MSG_1P;
      disp_id_reg    <= MSG_1P;
      disp_bcd_reg   <= '0;
      disp_valid_reg <= 1'b0;
      off_reg        <= '0;
      scroll_cnt_reg <= '0;
    end else begin
      if (bus.msg_load) begin
        id_reg         <= msg_id_t'(bus.msg_sel);
        scroll_cnt_reg <= '0;
      end
      if (update) begin
        disp_valid_reg <= 1'b1;
        disp_id_reg    <= id_reg;
        disp_bcd_reg   <= conv_bcd;
        off_reg        <= '0;
        scroll_cnt_reg <= '0;
      end else if (state_reg == ST_SCROLL && !bus.msg_load) begin
        if (scroll_cnt_reg == SCROLL_LAST) begin
          scroll_cnt_reg <= '0;
          off_reg        <= (off_reg == disp_len) ? 4'd0 : off_reg + 4'd1;
        end else begin
          scroll_cnt_reg <= scroll_cnt_reg + SCROLL_CW'(1);
        end
      end
    end
  end

`ifdef HEX_BLINK_EN
  localparam int BLINK_DIV = CLK_HZ / BLINK_HZ;
  localparam int BLINK_CW  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_CW-1:0] BLINK_LAST = BLINK_CW'(BLINK_DIV - 1);

  logic [BLINK_CW-1:0] blink_cnt_reg;
  logic                blank_reg;
  logic                blink_active;

  assign blink_active = (state_reg == ST_SHOW || state_reg == ST_SCROLL) &&
                        (disp_id_reg == MSG_P1 || disp_id_reg == MSG_P2 || disp_id_reg == MSG_EQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg <= '0;
      blank_reg     <= 1'b0;
    end else if (bus.msg_load) begin
      blink_cnt_reg <= '0;
    end else if (update) begin
      blink_cnt_reg <= '0;
      blank_reg     <= 1'b0;
    end else if (blink_active) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg <= '0;
        blank_reg     <= ~blank_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BLINK_CW'(1);
      end
    end
  end

  assign blank_w = blank_reg;
`else
  assign blank_w = 1'b0;
`endif

  // Digit gi shows text position (N_DIGITS-1-gi) of the window; only scrolling text wraps.
  for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
    localparam logic [3:0] POS = 4'(N_DIGITS - 1 - gi);
    logic [3:0] idx_w;
    logic [6:0] seg_w;

    always_comb begin
      idx_w = off_reg + POS;
      if (disp_wrap && idx_w > disp_len)
        idx_w = idx_w - (disp_len + 4'd1);
      if (!disp_valid_reg || blank_w || idx_w >= disp_len)
        seg_w = SEG_SPACE;
      else
        seg_w = glyph(msg_char(disp_id_reg, idx_w, disp_bcd_reg));
    end

    assign hex_w[gi*7 +: 7] = seg_w;
  end

  assign bus.hex_out   = hex_w;
  assign bus.busy      = conv_busy;
  assign bus.scrolling = (state_reg == ST_SCROLL);

endmodule

// File: tb/tb_hextext_scroller.sv
// Directed bench for hextext_scroller with CLK_HZ=8, SCROLL_HZ=2, BLINK_HZ=1, 6 digits.
module tb_hextext_scroller;

  localparam logic [6:0] G_0 = 7'h40, G_1 = 7'h79, G_2 = 7'h24, G_4 = 7'h19, G_7 = 7'h78;
  localparam logic [6:0] G_E = 7'h06, G_F = 7'h0E, G_G = 7'h42, G_H = 7'h09, G_I = 7'h4F;
  localparam logic [6:0] G_P = 7'h0C, G_Q = 7'h18, G_T = 7'h07, G_DASH = 7'h3F, G_BL = 7'h7F;
  localparam logic [41:0] ALL1 = {42{1'b1}};

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  hextext_scroller_if #(.N_DIGITS(6), .NUM_W(7)) bus ();

  hextext_scroller #(
    .N_DIGITS(6), .CLK_HZ(8), .SCROLL_HZ(2), .BLINK_HZ(1), .NUM_W(7)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Expected window of "P1- 42-" plus trailing blank (period 8) at offset off.
  function automatic logic [41:0] win_p1_42(input int off);
    logic [6:0]  txt [8];
    logic [41:0] w;
    txt = '{G_P, G_1, G_DASH, G_BL, G_4, G_2, G_DASH, G_BL};
    w = '0;
    for (int k = 0; k < 6; k++) w[(5-k)*7 +: 7] = txt[(off + k) % 8];
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input logic [2:0] id, input logic [6:0] num);
    bus.msg_sel  = id;
    bus.number   = num;
    bus.msg_load = 1'b1;
    tick();
    bus.msg_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.msg_load = 1'b0;
    bus.msg_sel  = 3'd0;
    bus.number   = 7'd0;
    #2;
    total++;
    if (bus.hex_out !== ALL1) begin
      $display("FAIL reset_hex got=%h want=%h", bus.hex_out, ALL1); bad++;
    end
    total++;
    if (bus.busy !== 1'b0 || bus.scrolling !== 1'b0) begin
      $display("FAIL reset_flags got busy=%b scrolling=%b want 0 0", bus.busy, bus.scrolling); bad++;
    end
    ticks(2);
    rst_n = 1'b1;
    tick();
    $display("reset: hex=%h busy=%b scrolling=%b", bus.hex_out, bus.busy, bus.scrolling);
  endtask

  task automatic test_fight();
    logic [41:0] exp_w;
    int          diffs;
    exp_w = {G_F, G_I, G_G, G_H, G_T, G_BL};
    load(3'd2, 7'd0);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (bus.busy !== 1'b1) begin
        $display("FAIL fight_busy cycle %0d got=%b want=1", i, bus.busy); bad++;
      end
      if (i < 6) tick();
    end
    tick();
    total++;
    if (bus.busy !== 1'b0 || bus.hex_out !== ALL1) begin
      $display("FAIL fight_pre_update got busy=%b hex=%h want busy=0 hex=%h", bus.busy, bus.hex_out, ALL1); bad++;
    end
    tick();
    total++;
    if (bus.hex_out !== exp_w || bus.scrolling !== 1'b0) begin
      $display("FAIL fight_show got hex=%h scrolling=%b want hex=%h scrolling=0", bus.hex_out, bus.scrolling, exp_w); bad++;
    end
    diffs = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.hex_out !== exp_w || bus.scrolling !== 1'b0) diffs++;
    end
    total++;
    if (diffs != 0) begin
      $display("FAIL fight_stable got %0d changed cycles want 0", diffs); bad++;
    end
    $display("fight: hex=%h scrolling=%b", bus.hex_out, bus.scrolling);
  endtask

  task automatic test_scroll_p1();
    load(3'd3, 7'd42);
    ticks(8);
    total++;
    if (bus.hex_out !== win_p1_42(0) || bus.scrolling !== 1'b1) begin
      $display("FAIL p1_first got hex=%h scrolling=%b want hex=%h scrolling=1", bus.hex_out, bus.scrolling, win_p1_42(0)); bad++;
    end
    for (int s = 1; s <= 8; s++) begin
      ticks(3);
      total++;
      if (bus.hex_out !== win_p1_42(s - 1)) begin
        $display("FAIL p1_hold step %0d got=%h want=%h", s, bus.hex_out, win_p1_42(s - 1)); bad++;
      end
      tick();
      total++;
      if (bus.hex_out !== win_p1_42(s % 8)) begin
        $display("FAIL p1_step step %0d got=%h want=%h", s, bus.hex_out, win_p1_42(s % 8)); bad++;
      end
    end
    $display("scroll: hex=%h after 8 steps", bus.hex_out);
  endtask

  task automatic test_eq();
    logic [41:0] eq0, eq127, eq127_s1;
    eq0      = {G_E, G_Q, G_DASH, G_BL, G_BL, G_0};
    eq127    = {G_E, G_Q, G_DASH, G_1, G_2, G_7};
    eq127_s1 = {G_Q, G_DASH, G_1, G_2, G_7, G_DASH};
    load(3'd5, 7'd0);
    ticks(8);
    total++;
    if (bus.hex_out !== eq0) begin
      $display("FAIL eq_zero got=%h want=%h", bus.hex_out, eq0); bad++;
    end
    load(3'd5, 7'd127);
    ticks(7);
    total++;
    if (bus.hex_out !== eq0) begin
      $display("FAIL eq_conv_hold got=%h want=%h", bus.hex_out, eq0); bad++;
    end
    tick();
    total++;
    if (bus.hex_out !== eq127) begin
      $display("FAIL eq_127 got=%h want=%h", bus.hex_out, eq127); bad++;
    end
    ticks(3);
    total++;
    if (bus.hex_out !== eq127) begin
      $display("FAIL eq_127_hold got=%h want=%h", bus.hex_out, eq127); bad++;
    end
    tick();
    total++;
    if (bus.hex_out !== eq127_s1) begin
      $display("FAIL eq_127_step got=%h want=%h", bus.hex_out, eq127_s1); bad++;
    end
    $display("eq: hex=%h", bus.hex_out);
  endtask

  task automatic test_restart();
    logic [41:0] exp_w;
    int          diffs;
    exp_w = {G_2, G_P, G_BL, G_BL, G_BL, G_BL};
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    load(3'd4, 7'd5);
    ticks(2);
    load(3'd1, 7'd0);
    diffs = 0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (bus.hex_out !== ALL1) diffs++;
      if (i == 4) begin
        total++;
        if (bus.busy !== 1'b1) begin
          $display("FAIL restart_busy got=%b want=1", bus.busy); bad++;
        end
      end
    end
    total++;
    if (diffs != 0) begin
      $display("FAIL restart_blank got %0d non-blank cycles want 0", diffs); bad++;
    end
    tick();
    total++;
    if (bus.hex_out !== exp_w || bus.scrolling !== 1'b0) begin
      $display("FAIL restart_show got hex=%h scrolling=%b want hex=%h scrolling=0", bus.hex_out, bus.scrolling, exp_w); bad++;
    end
    $display("restart: hex=%h", bus.hex_out);
  endtask

  task automatic test_blink_and_async_reset();
    logic [41:0] exp8, exp15;
`ifdef HEX_BLINK_EN
    exp8  = ALL1;
    exp15 = ALL1;
`else
    exp8  = win_p1_42(2);
    exp15 = win_p1_42(3);
`endif
    load(3'd3, 7'd42);
    ticks(8);
    total++;
    if (bus.hex_out !== win_p1_42(0)) begin
      $display("FAIL blink_u0 got=%h want=%h", bus.hex_out, win_p1_42(0)); bad++;
    end
    ticks(7);
    total++;
    if (bus.hex_out !== win_p1_42(1)) begin
      $display("FAIL blink_u7 got=%h want=%h", bus.hex_out, win_p1_42(1)); bad++;
    end
    tick();
    total++;
    if (bus.hex_out !== exp8) begin
      $display("FAIL blink_u8 got=%h want=%h", bus.hex_out, exp8); bad++;
    end
    ticks(7);
    total++;
    if (bus.hex_out !== exp15) begin
      $display("FAIL blink_u15 got=%h want=%h", bus.hex_out, exp15); bad++;
    end
    tick();
    total++;
    if (bus.hex_out !== win_p1_42(4) || bus.scrolling !== 1'b1) begin
      $display("FAIL blink_u16 got hex=%h scrolling=%b want hex=%h scrolling=1", bus.hex_out, bus.scrolling, win_p1_42(4)); bad++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.hex_out !== ALL1 || bus.busy !== 1'b0 || bus.scrolling !== 1'b0) begin
      $display("FAIL async_reset got hex=%h busy=%b scrolling=%b want hex=%h busy=0 scrolling=0", bus.hex_out, bus.busy, bus.scrolling, ALL1); bad++;
    end
    #10;
    rst_n = 1'b1;
    tick();
    $display("blink/async reset: hex=%h scrolling=%b", bus.hex_out, bus.scrolling);
  endtask

  initial begin
    test_reset();
    test_fight();
    test_scroll_p1();
    test_eq();
    test_restart();
    test_blink_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
